// File: rtl/lbm_pkg.sv
// Shared LBM definitions: per-direction field width, moment widths and the
// 144-bit distribution beat layout {null,n,ne,e,se,s,sw,w,nw} (null at MSBs).
// The BRAM readout stage packs beats with the same direction indices.
package lbm_pkg;

    localparam int DIR_WIDTH  = 16;
    localparam int NUM_DIRS   = 9;
    localparam int BEAT_WIDTH = NUM_DIRS * DIR_WIDTH;

    localparam int RHO_WIDTH  = 20;
    localparam int MOM_WIDTH  = 18;
    // Partial sums add three 16-bit values, so 18 bits hold them exactly.
    localparam int PSUM_WIDTH = 18;

    // Direction index inside a beat; index i lives at bits [16*i +: 16].
    localparam int DIR_NW   = 0;
    localparam int DIR_W    = 1;
    localparam int DIR_SW   = 2;
    localparam int DIR_S    = 3;
    localparam int DIR_SE   = 4;
    localparam int DIR_E    = 5;
    localparam int DIR_NE   = 6;
    localparam int DIR_N    = 7;
    localparam int DIR_NULL = 8;

    typedef logic [DIR_WIDTH-1:0]  dir_t;
    typedef logic [PSUM_WIDTH-1:0] psum_w_t;

    // Stage-1 partial sums. rest = null + n + s, so rho = east + west + rest.
    typedef struct packed {
        psum_w_t east;
        psum_w_t west;
        psum_w_t north;
        psum_w_t south;
        psum_w_t rest;
    } psum_t;

    function automatic dir_t get_dir(input logic [BEAT_WIDTH-1:0] beat, input int idx);
        return beat[idx*DIR_WIDTH +: DIR_WIDTH];
    endfunction

    function automatic psum_w_t ext_dir(input logic [BEAT_WIDTH-1:0] beat, input int idx);
        return PSUM_WIDTH'(get_dir(beat, idx));
    endfunction

endpackage

// File: rtl/lbm_moment_calc.sv
// Two-stage moment datapath: beat -> partial sums -> rho/mx/my.
// Latency 2 enabled cycles; both stages advance together only when en_i is high.
// No handshake here: the caller gates en_i with its own backpressure.
// Ports: clk_i/rst_i (async active-high), en_i stage advance, beat_i packed
// distributions, rho_o/mx_o/my_o registered stage-2 moments.
module lbm_moment_calc
    import lbm_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [BEAT_WIDTH-1:0] beat_i,
    output logic [RHO_WIDTH-1:0]  rho_o,
    output logic [MOM_WIDTH-1:0]  mx_o,
    output logic [MOM_WIDTH-1:0]  my_o
);

    psum_t                ps_d, ps_q;
    logic [RHO_WIDTH-1:0] rho_d, rho_q;
    logic [MOM_WIDTH-1:0] mx_d, mx_q;
    logic [MOM_WIDTH-1:0] my_d, my_q;

    // Diagonals feed both the x and y sums, hence the duplicated terms.
    always_comb begin
        ps_d       = '0;
        ps_d.east  = ext_dir(beat_i, DIR_NE) + ext_dir(beat_i, DIR_E) + ext_dir(beat_i, DIR_SE);
        ps_d.west  = ext_dir(beat_i, DIR_NW) + ext_dir(beat_i, DIR_W) + ext_dir(beat_i, DIR_SW);
        ps_d.north = ext_dir(beat_i, DIR_N)  + ext_dir(beat_i, DIR_NE) + ext_dir(beat_i, DIR_NW);
        ps_d.south = ext_dir(beat_i, DIR_S)  + ext_dir(beat_i, DIR_SE) + ext_dir(beat_i, DIR_SW);
        ps_d.rest  = ext_dir(beat_i, DIR_NULL) + ext_dir(beat_i, DIR_N) + ext_dir(beat_i, DIR_S);
    end

    // Sum of three 18-bit values stays below 2^20; moment differences wrap
    // modulo 2^18 as two's complement.
    always_comb begin
        rho_d = RHO_WIDTH'(ps_q.east) + RHO_WIDTH'(ps_q.west) + RHO_WIDTH'(ps_q.rest);
        mx_d  = MOM_WIDTH'(ps_q.east - ps_q.west);
        my_d  = MOM_WIDTH'(ps_q.north - ps_q.south);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ps_q  <= '0;
            rho_q <= '0;
            mx_q  <= '0;
            my_q  <= '0;
        end else if (en_i) begin
            ps_q  <= ps_d;
            rho_q <= rho_d;
            mx_q  <= mx_d;
            my_q  <= my_d;
        end
    end

    assign rho_o = rho_q;
    assign mx_o  = mx_q;
    assign my_o  = my_q;

endmodule

// File: rtl/lbm_moment_stream.sv
// AXI4-Stream moment reducer: one 144-bit distribution beat in, one 64-bit
// {8'd0, rho, mx, my} beat out per pixel, with locally regenerated framing.
// Latency 2 cycles; a single global enable stalls the whole pipe when the
// output is valid and not ready, so s00_axis_tready mirrors m00_axis_tready.
// Ports: s00_* input stream (tstrb ignored), m00_* output stream,
// frame_done pulse / frame_count per completed output frame, sticky tlast_err.
module lbm_moment_stream
    import lbm_pkg::*;
#(
    parameter int DEPTH           = 2500,
    parameter int CNT_WIDTH       = 12,   // 2**CNT_WIDTH must exceed DEPTH
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       s00_axis_aclk,
    input  logic                       s00_axis_areset,
    input  logic [BEAT_WIDTH-1:0]      s00_axis_tdata,
    input  logic                       s00_axis_tvalid,
    output logic                       s00_axis_tready,
    input  logic                       s00_axis_tlast,
    input  logic [BEAT_WIDTH/8-1:0]    s00_axis_tstrb,
    output logic [63:0]                m00_axis_tdata,
    output logic                       m00_axis_tvalid,
    input  logic                       m00_axis_tready,
    output logic                       m00_axis_tlast,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       tlast_err
);

    logic                       en;
    logic                       in_hs;
    logic                       out_hs;
    logic                       frame_hs;
    logic                       at_end;

    logic [CNT_WIDTH-1:0]       pix_cnt_d, pix_cnt_q;
    logic                       tlast_err_d, tlast_err_q;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_d, frame_cnt_q;
    logic                       frame_done_q;
    logic                       v1_q, l1_q;
    logic                       v2_q, l2_q;

    logic [RHO_WIDTH-1:0]       rho;
    logic [MOM_WIDTH-1:0]       mx;
    logic [MOM_WIDTH-1:0]       my;

    // All bytes are treated as valid.
    logic                       unused_tstrb;
    assign unused_tstrb = ^s00_axis_tstrb;

    assign en              = !v2_q || m00_axis_tready;
    assign s00_axis_tready = en && !s00_axis_areset;
    assign in_hs           = s00_axis_tvalid && s00_axis_tready;
    assign out_hs          = v2_q && m00_axis_tready;
    assign frame_hs        = out_hs && l2_q;
    assign at_end          = (pix_cnt_q == CNT_WIDTH'(DEPTH - 1));

    // Upstream tlast resynchronises the counter: an early tlast restarts the
    // frame at the next beat; a missing one is only flagged, the count wraps anyway.
    always_comb begin
        pix_cnt_d   = pix_cnt_q;
        tlast_err_d = tlast_err_q;
        if (in_hs) begin
            if (at_end || s00_axis_tlast) begin
                pix_cnt_d = '0;
            end else begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
            if (at_end != s00_axis_tlast) begin
                tlast_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_hs) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            pix_cnt_q    <= '0;
            tlast_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
            v1_q         <= 1'b0;
            l1_q         <= 1'b0;
            v2_q         <= 1'b0;
            l2_q         <= 1'b0;
        end else begin
            pix_cnt_q    <= pix_cnt_d;
            tlast_err_q  <= tlast_err_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_hs;
            if (en) begin
                // en high outside reset implies tready, so in_hs == tvalid here;
                // a low tvalid loads a bubble.
                v1_q <= in_hs;
                l1_q <= in_hs && at_end;
                v2_q <= v1_q;
                l2_q <= l1_q;
            end
        end
    end

    lbm_moment_calc u_calc (
        .clk_i  (s00_axis_aclk),
        .rst_i  (s00_axis_areset),
        .en_i   (en),
        .beat_i (s00_axis_tdata),
        .rho_o  (rho),
        .mx_o   (mx),
        .my_o   (my)
    );

    assign m00_axis_tdata  = {8'd0, rho, mx, my};
    assign m00_axis_tvalid = v2_q;
    assign m00_axis_tlast  = l2_q;
    assign frame_done      = frame_done_q;
    assign frame_count     = frame_cnt_q;
    assign tlast_err       = tlast_err_q;

endmodule

// File: tb/tb_lbm_moment_stream.sv
module tb_lbm_moment_stream;

    localparam int DEPTH = 2500;

    logic          clk = 1'b0;
    logic          rst;
    logic [143:0]  s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [17:0]   s_tstrb;
    logic [63:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          tlast_err;

    always #5 clk = ~clk;

    lbm_moment_stream #(.DEPTH(DEPTH), .CNT_WIDTH(12), .FRAME_CNT_WIDTH(16)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tstrb  (s_tstrb),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tlast  (m_tlast),
        .frame_done      (frame_done),
        .frame_count     (frame_count),
        .tlast_err       (tlast_err)
    );

    typedef struct packed {
        logic [15:0] nul, n, ne, e, se, s, sw, w, nw;
        logic [19:0] rho;
        logic [17:0] mx, my;
    } vec_t;

    vec_t tbl [6];

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard / monitor state, written only by the monitor process.
    logic [63:0] exp_q [$];
    int  out_idx, last_idx, last_cnt, data_bad, stall_bad, rdy_bad, fd_cnt;
    bit  stalled_prev;
    logic [63:0] held_dat;
    logic        held_last;
    bit  bp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [143:0] pack(input vec_t v);
        return {v.nul, v.n, v.ne, v.e, v.se, v.s, v.sw, v.w, v.nw};
    endfunction

    // Reference moments straight from the definitions, in 32-bit integers.
    function automatic logic [63:0] model(input logic [143:0] d);
        int v [9];
        int rho, mx, my;
        logic [19:0] r20;
        logic [17:0] x18, y18;
        for (int k = 0; k < 9; k++) v[k] = int'(d[k*16 +: 16]);
        rho = 0;
        for (int k = 0; k < 9; k++) rho += v[k];
        // index: nw0 w1 sw2 s3 se4 e5 ne6 n7 null8
        mx = (v[6] + v[5] + v[4]) - (v[0] + v[1] + v[2]);
        my = (v[7] + v[6] + v[0]) - (v[3] + v[4] + v[2]);
        r20 = 20'(rho);
        x18 = 18'(mx);
        y18 = 18'(my);
        return {8'd0, r20, x18, y18};
    endfunction

    // Output backpressure: 1-0-0-1 pattern when enabled, else always ready.
    initial begin
        int ph = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                m_tready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                m_tready = 1'b1;
            end
        end
    end

    // Monitor on the falling edge, where all inputs are settled.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                out_idx = 0; last_idx = -1; last_cnt = 0; data_bad = 0;
                stall_bad = 0; rdy_bad = 0; fd_cnt = 0; stalled_prev = 1'b0;
            end else begin
                if (stalled_prev && (!m_tvalid || m_tdata !== held_dat || m_tlast !== held_last))
                    stall_bad++;
                stalled_prev = m_tvalid && !m_tready;
                held_dat     = m_tdata;
                held_last    = m_tlast;
                if (m_tvalid && (s_tready !== m_tready)) rdy_bad++;
                if (frame_done) fd_cnt++;
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        data_bad++;
                    end else begin
                        if (m_tdata !== exp_q.pop_front()) data_bad++;
                    end
                    if (m_tlast) begin
                        last_cnt++;
                        last_idx = out_idx;
                    end
                    out_idx++;
                end
                if (s_tvalid && s_tready) exp_q.push_back(model(s_tdata));
            end
        end
    end

    task automatic send_beat(input logic [143:0] d, input logic lst);
        int waitc = 0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = lst;
        forever begin
            @(negedge clk);
            if (s_tready) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waitc++;
            if (waitc > 100) begin
                n_chk++;
                n_fail++;
                $display("FAIL in_handshake_timeout: got no tready in %0d cycles, expected tready", waitc);
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_stream(input int nbeats, input int tlast_at, input bit varied);
        logic [143:0] d;
        for (int i = 0; i < nbeats; i++) begin
            if (varied) begin
                for (int k = 0; k < 9; k++) d[k*16 +: 16] = 16'(i * 977 + k * 12345 + 1);
            end else begin
                d = {9{16'h1000}};
            end
            send_beat(d, i == tlast_at);
        end
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 500) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // 18'h10003 is -196605 reduced modulo 2^18; 18'h3FFF7 is -9.
        tbl[0] = '{nul:16'd0, n:16'd7, ne:16'd10, e:16'd100, se:16'd0, s:16'd2, sw:16'd0, w:16'd30, nw:16'd0,
                   rho:20'd149, mx:18'd80, my:18'd15};
        tbl[1] = '{nul:16'd0, n:16'd0, ne:16'd0, e:16'd0, se:16'd0, s:16'd0, sw:16'hFFFF, w:16'hFFFF, nw:16'hFFFF,
                   rho:20'h2FFFD, mx:18'h10003, my:18'd0};
        tbl[2] = '{nul:16'hFFFF, n:16'hFFFF, ne:16'hFFFF, e:16'hFFFF, se:16'hFFFF, s:16'hFFFF, sw:16'hFFFF,
                   w:16'hFFFF, nw:16'hFFFF, rho:20'h8FFF7, mx:18'd0, my:18'd0};
        tbl[3] = '{nul:16'd0, n:16'hFFFF, ne:16'hFFFF, e:16'd0, se:16'd0, s:16'd0, sw:16'd0, w:16'd0, nw:16'hFFFF,
                   rho:20'h2FFFD, mx:18'd0, my:18'h2FFFD};
        tbl[4] = '{nul:16'd1000, n:16'd0, ne:16'd0, e:16'd0, se:16'd3, s:16'd5, sw:16'd1, w:16'd0, nw:16'd0,
                   rho:20'd1009, mx:18'd2, my:18'h3FFF7};
        tbl[5] = '{nul:16'h1000, n:16'h1000, ne:16'h1000, e:16'h1000, se:16'h1000, s:16'h1000, sw:16'h1000,
                   w:16'h1000, nw:16'h1000, rho:20'h09000, mx:18'd0, my:18'd0};

        rst      = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tstrb  = '0;

        // Reset state.
        @(negedge clk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_m_tdata", m_tdata, 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_tlast_err", 64'(tlast_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table vectors: single beats, two-cycle latency, exact moments.
        for (int i = 0; i < 6; i++) begin
            s_tdata  = pack(tbl[i]);
            s_tvalid = 1'b1;
            s_tstrb  = 18'(i * 7);
            @(negedge clk);
            check($sformatf("vec%0d_s_tready", i), 64'(s_tready), 64'd1);
            @(posedge clk);
            #1;
            s_tvalid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_lat1_valid", i), 64'(m_tvalid), 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_lat2_valid", i), 64'(m_tvalid), 64'd1);
            check($sformatf("vec%0d_data", i), m_tdata, {8'd0, tbl[i].rho, tbl[i].mx, tbl[i].my});
            check($sformatf("vec%0d_tlast", i), 64'(m_tlast), 64'd0);
            @(posedge clk);
            #1;
        end
        s_tstrb = '1;

        // Uniform full frame with matching upstream tlast.
        do_reset();
        send_stream(DEPTH, DEPTH - 1, 1'b0);
        drain();
        check("uni_beats", 64'(out_idx), 64'(DEPTH));
        check("uni_data_bad", 64'(data_bad), 64'd0);
        check("uni_tlast_cnt", 64'(last_cnt), 64'd1);
        check("uni_tlast_idx", 64'(last_idx), 64'(DEPTH - 1));
        check("uni_frame_done_pulses", 64'(fd_cnt), 64'd1);
        check("uni_frame_count", 64'(frame_count), 64'd1);
        check("uni_tlast_err", 64'(tlast_err), 64'd0);

        // Backpressure 1-0-0-1 over 50 varied beats.
        do_reset();
        bp_en = 1'b1;
        send_stream(50, -1, 1'b1);
        drain();
        bp_en = 1'b0;
        check("bp_beats", 64'(out_idx), 64'd50);
        check("bp_data_bad", 64'(data_bad), 64'd0);
        check("bp_stall_unstable", 64'(stall_bad), 64'd0);
        check("bp_s_tready_follow", 64'(rdy_bad), 64'd0);

        // Early upstream tlast on beat 100: next beat restarts at pixel 0.
        do_reset();
        send_stream(100, -1, 1'b0);
        check("early_err_before", 64'(tlast_err), 64'd0);
        send_stream(1, 0, 1'b0);
        check("early_err_set", 64'(tlast_err), 64'd1);
        send_stream(DEPTH, -1, 1'b0);
        drain();
        check("early_err_sticky", 64'(tlast_err), 64'd1);
        check("early_tlast_cnt", 64'(last_cnt), 64'd1);
        check("early_tlast_idx", 64'(last_idx), 64'(101 + DEPTH - 1));
        check("early_data_bad", 64'(data_bad), 64'd0);

        // Reset mid-frame at beat 1200, then a full frame without upstream tlast.
        do_reset();
        send_stream(1200, -1, 1'b0);
        check("mid_valid_before_rst", 64'(m_tvalid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_m_tdata", m_tdata, 64'd0);
        check("mid_rst_m_tlast", 64'(m_tlast), 64'd0);
        check("mid_rst_s_tready", 64'(s_tready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_stream(DEPTH - 1, -1, 1'b1);
        check("miss_err_before", 64'(tlast_err), 64'd0);
        send_stream(1, -1, 1'b1);
        check("miss_err_set", 64'(tlast_err), 64'd1);
        drain();
        check("mid_beats", 64'(out_idx), 64'(DEPTH));
        check("mid_data_bad", 64'(data_bad), 64'd0);
        check("mid_tlast_idx", 64'(last_idx), 64'(DEPTH - 1));
        check("mid_tlast_cnt", 64'(last_cnt), 64'd1);
        check("mid_frame_count", 64'(frame_count), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
